sipo_collector: RTL and testbench

- Downstream companion to the 3-word parallel-in/serial-out (PISO) stage.
- Captures a framed stream of WIDTH-bit words, one per cycle, and reassembles NWORDS consecutive words into one parallel bundle.
- Presents the bundle to the consumer with a valid/ready handshake.
- Flags protocol errors: a frame restarted mid-collection, and words arriving while a completed bundle is still held.

---
 rtl/sipo_collector_pkg.sv | 19 +
 rtl/sipo_collector_if.sv | 32 +++
 rtl/sipo_collector.sv | 106 ++++++++++
 tb/tb_sipo_collector.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/sipo_collector_pkg.sv
// Shared definitions for the PISO/SIPO word-serial link: state encoding and
// default frame geometry.
package sipo_collector_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_NWORDS = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    // Slot index width; a single-word frame would still need one bit.
    function automatic int idx_width(input int nwords);
        return (nwords > 1) ? $clog2(nwords) : 1;
    endfunction

endpackage

// File: rtl/sipo_collector_if.sv
// Serial word input plus parallel bundle output with valid/ready handshake
// and protocol-error pulses.
interface sipo_collector_if
    import sipo_collector_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NWORDS = DEF_NWORDS
);

    logic [WIDTH-1:0]        i_word;
    logic                    i_valid;
    logic                    i_start;
    logic                    o_accept;
    logic [NWORDS*WIDTH-1:0] o_parallel;
    logic                    o_valid;
    logic                    i_ready;
    logic                    o_restart_err;
    logic                    o_drop;

    // Producer and consumer side (upstream PISO + bundle sink).
    modport master (
        output i_word, i_valid, i_start, i_ready,
        input  o_accept, o_parallel, o_valid, o_restart_err, o_drop
    );

    // Collector side.
    modport slave (
        input  i_word, i_valid, i_start, i_ready,
        output o_accept, o_parallel, o_valid, o_restart_err, o_drop
    );

endinterface

// File: rtl/sipo_collector.sv
// Reassembles NWORDS framed serial words into one parallel bundle and hands it
// to the consumer over valid/ready, flagging restarts and overruns.
module sipo_collector
    import sipo_collector_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NWORDS = DEF_NWORDS
) (
    input  logic             i_clk,
    input  logic             i_rst,
    sipo_collector_if.slave  bus
);

    localparam int IDX_W = idx_width(NWORDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [NWORDS-1:0] slot_we;
    logic [WIDTH-1:0]  slot_q [NWORDS];

    // Slot write enables: a start word always lands in slot 0, even mid-frame.
    always_comb begin
        slot_we = '0;
        if (bus.i_valid) begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_start) slot_we[0] = 1'b1;
                end
                ST_COLLECT: begin
                    if (bus.i_start) slot_we[0] = 1'b1;
                    else             slot_we[idx] = 1'b1;
                end
                default: slot_we = '0;
            endcase
        end
    end

    for (genvar g = 0; g < NWORDS; g++) begin : g_slot
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst)            slot_q[g] <= '0;
            else if (slot_we[g])  slot_q[g] <= bus.i_word;
        end
    end

    always_comb begin
        bus.o_parallel = '0;
        for (int k = 0; k < NWORDS; k++) begin
            bus.o_parallel[k*WIDTH +: WIDTH] = slot_q[k];
        end
    end

    // Control FSM; every output is registered alongside the state it reflects.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state             <= ST_IDLE;
            idx               <= '0;
            bus.o_valid       <= 1'b0;
            bus.o_accept      <= 1'b1;
            bus.o_restart_err <= 1'b0;
            bus.o_drop        <= 1'b0;
        end else begin
            bus.o_restart_err <= 1'b0;
            bus.o_drop        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.i_valid && bus.i_start) begin
                        idx   <= IDX_ONE;
                        state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (bus.i_valid) begin
                        if (bus.i_start) begin
                            bus.o_restart_err <= 1'b1;
                            idx               <= IDX_ONE;
                        end else if (idx == IDX_LAST) begin
                            idx          <= '0;
                            state        <= ST_FULL;
                            bus.o_valid  <= 1'b1;
                            bus.o_accept <= 1'b0;
                        end else begin
                            idx <= idx + IDX_ONE;
                        end
                    end
                end
                ST_FULL: begin
                    if (bus.i_valid) bus.o_drop <= 1'b1;
                    if (bus.i_ready) begin
                        state        <= ST_IDLE;
                        bus.o_valid  <= 1'b0;
                        bus.o_accept <= 1'b1;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    idx          <= '0;
                    bus.o_valid  <= 1'b0;
                    bus.o_accept <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_collector.sv
// Directed bench for sipo_collector with hand-computed bundles and flag timing.
module tb_sipo_collector;

    localparam int WIDTH  = 32;
    localparam int NWORDS = 3;
    localparam int PW     = NWORDS * WIDTH;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sipo_collector_if #(.WIDTH(WIDTH), .NWORDS(NWORDS)) bus ();

    sipo_collector #(.WIDTH(WIDTH), .NWORDS(NWORDS)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] w, input logic s);
        bus.i_word  = w;
        bus.i_start = s;
        bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        bus.i_start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [PW-1:0] held;

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.i_word  = '0;
        bus.i_valid = 1'b0;
        bus.i_start = 1'b0;
        bus.i_ready = 1'b0;
        idle(2);
        check("rst_valid",    PW'(bus.o_valid), PW'(0));
        check("rst_accept",   PW'(bus.o_accept), PW'(1));
        check("rst_parallel", bus.o_parallel, '0);
        check("rst_flags",    PW'({bus.o_restart_err, bus.o_drop}), PW'(0));
        rst = 1'b0;
        idle(1);

        // Reset mid-frame clears immediately, without a clock edge.
        send(32'hAAAA0001, 1'b1);
        send(32'hBBBB0002, 1'b0);
        check("pre_rst_parallel", bus.o_parallel, 96'h00000000_BBBB0002_AAAA0001);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid",    PW'(bus.o_valid), PW'(0));
        check("async_rst_parallel", bus.o_parallel, '0);
        check("async_rst_accept",   PW'(bus.o_accept), PW'(1));
        #2 rst = 1'b0;
        idle(1);

        // Gapless frame with ready tied high.
        bus.i_ready = 1'b1;
        send(32'h11111111, 1'b1);
        send(32'h22222222, 1'b0);
        check("gapless_not_yet", PW'(bus.o_valid), PW'(0));
        send(32'h33333333, 1'b0);
        check("gapless_valid",    PW'(bus.o_valid), PW'(1));
        check("gapless_accept",   PW'(bus.o_accept), PW'(0));
        check("gapless_parallel", bus.o_parallel, 96'h33333333_22222222_11111111);
        tick();
        check("gapless_consumed", PW'(bus.o_valid), PW'(0));
        check("gapless_accept_back", PW'(bus.o_accept), PW'(1));

        // Gaps between words, then backpressure for five cycles.
        bus.i_ready = 1'b0;
        send(32'h00000001, 1'b1);
        idle(2);
        send(32'h00000002, 1'b0);
        idle(2);
        check("gap_partial_valid", PW'(bus.o_valid), PW'(0));
        send(32'h00000003, 1'b0);
        check("gap_valid", PW'(bus.o_valid), PW'(1));
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_valid_%0d", i),    PW'(bus.o_valid), PW'(1));
            check($sformatf("bp_accept_%0d", i),   PW'(bus.o_accept), PW'(0));
            check($sformatf("bp_parallel_%0d", i), bus.o_parallel, 96'h00000003_00000002_00000001);
        end
        bus.i_ready = 1'b1;
        tick();
        check("bp_consumed", PW'(bus.o_valid), PW'(0));
        check("bp_idle_accept", PW'(bus.o_accept), PW'(1));
        bus.i_ready = 1'b0;

        // Restart mid-frame.
        send(32'h0000000A, 1'b1);
        check("rs_first_start", PW'(bus.o_restart_err), PW'(0));
        send(32'h0000000B, 1'b0);
        send(32'h0000000C, 1'b1);
        check("rs_pulse", PW'(bus.o_restart_err), PW'(1));
        send(32'h0000000D, 1'b0);
        check("rs_pulse_end", PW'(bus.o_restart_err), PW'(0));
        check("rs_not_full",  PW'(bus.o_valid), PW'(0));
        send(32'h0000000E, 1'b0);
        check("rs_valid",    PW'(bus.o_valid), PW'(1));
        check("rs_parallel", bus.o_parallel, 96'h0000000E_0000000D_0000000C);

        // Overrun while FULL.
        send(32'h0000DEAD, 1'b0);
        check("ovr_drop",     PW'(bus.o_drop), PW'(1));
        check("ovr_parallel", bus.o_parallel, 96'h0000000E_0000000D_0000000C);
        tick();
        check("ovr_drop_end", PW'(bus.o_drop), PW'(0));
        // Start word arriving in the same cycle the bundle is taken is still dropped.
        bus.i_ready = 1'b1;
        send(32'h0000BEEF, 1'b1);
        bus.i_ready = 1'b0;
        check("ovr2_drop",      PW'(bus.o_drop), PW'(1));
        check("ovr2_consumed",  PW'(bus.o_valid), PW'(0));
        check("ovr2_restart",   PW'(bus.o_restart_err), PW'(0));
        check("ovr2_parallel",  bus.o_parallel, 96'h0000000E_0000000D_0000000C);
        held = bus.o_parallel;

        // Orphan word in IDLE is ignored.
        send(32'h00000055, 1'b0);
        check("orphan_flags",    PW'({bus.o_restart_err, bus.o_drop}), PW'(0));
        check("orphan_valid",    PW'(bus.o_valid), PW'(0));
        check("orphan_accept",   PW'(bus.o_accept), PW'(1));
        check("orphan_parallel", bus.o_parallel, held);
        send(32'h00000007, 1'b1);
        send(32'h00000008, 1'b0);
        check("orphan_no_restart", PW'(bus.o_restart_err), PW'(0));
        send(32'h00000009, 1'b0);
        check("orphan_frame_valid", PW'(bus.o_valid), PW'(1));
        check("orphan_frame",       bus.o_parallel, 96'h00000009_00000008_00000007);
        bus.i_ready = 1'b1;
        tick();
        check("final_consumed", PW'(bus.o_valid), PW'(0));
        bus.i_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
